transform: RTL and testbench
============================

TRANSFORM -- requirements
Module: transform

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset named clk and reset; all state changes on rising clk.
REQ-002 Parameter: SCALE_W, 640, horizontal output scale numerator.
REQ-003 Parameter: SCALE_H, 480, vertical output scale numerator.
REQ-004 Port: clk  in  1  system clock.
REQ-005 Port: reset  in  1  synchronous active-high reset.
REQ-006 Port: start  in  1  one-cycle request; inputs sampled when start=1 in IDLE.
REQ-007 Port: t_width  in  11  target rectangle width, unsigned.
REQ-008 Port: t_height  in  10  target rectangle height, unsigned.
REQ-009 Port: x  in  11  source x coordinate, unsigned.
REQ-010 Port: y  in  10  source y coordinate, unsigned.
REQ-011 Port: cv_x  out  13  transformed x, registered.
REQ-012 Port: cv_y  out  13  transformed y, registered.
REQ-013 Port: done  out  1  one-cycle completion pulse.
REQ-014 Port: busy  out  1  high from the edge after start is accepted until the edge done rises.

Function
REQ-015 SHALL compute cv_x = floor(x*SCALE_W / t_width), cv_y = floor(y*SCALE_H / t_height), unsigned.
REQ-016 Products SHALL be 21 bits wide (11+10); quotients SHALL be 21 bits before output reduction to 13 bits.
REQ-017 FSM states: IDLE, MULT, DIV, DONE; IDLE->MULT on start (latch x, y, t_width, t_height); MULT->DIV after 1 cycle (register products); DIV runs 21 cycles (one quotient bit per cycle, both axes in parallel); DIV->DONE; DONE->IDLE after 1 cycle.
REQ-018 cv_x, cv_y and done SHALL update on the edge entering DONE, 23 edges after the edge sampling start; done high for exactly one cycle.
REQ-019 cv_x/cv_y SHALL hold their value until the next completion.
REQ-020 start while not in IDLE SHALL be ignored; no queuing.
REQ-021 Divisor 0 on an axis SHALL yield 8191 on that axis; the other axis computes normally.
REQ-022 Input changes after acceptance SHALL not affect the running computation.

Reset
REQ-023 reset SHALL force IDLE, cv_x=0, cv_y=0, done=0, busy=0 on the next edge, including mid-computation, discarding partial results.
REQ-024 reset SHALL take priority over start on the same edge.

Configuration
REQ-025 Macro TRANSFORM_SAT_EN defined: quotients > 8191 SHALL saturate to 8191.
REQ-026 Macro TRANSFORM_SAT_EN undefined: outputs SHALL be the low 13 bits of the quotient; divisor-0 result remains 8191.

Structure
REQ-027 Package transform_pkg SHALL hold the state enum, width constants (PROD_W=21, OUT_W=13) and OUT_MAX=8191.
REQ-028 Sub-module transform_div (sequential restoring divider, start/done, 21-bit dividend, 11-bit divisor) SHALL be instantiated once per axis.

Verification
REQ-029 t_width=80, t_height=80, x=230, y=340, start pulse -> done 23 cycles later; cv_x=1840, cv_y=2040.
REQ-030 t_width=0, t_height=480, x=100, y=479 -> cv_x=8191, cv_y=479.
REQ-031 x=2047, t_width=1, y=0, t_height=1 -> cv_x=8191 with TRANSFORM_SAT_EN, 7552 without; cv_y=0.
REQ-032 Second start with x=10 at cycle 5 of a run from REQ-029 -> single done pulse, cv_x=1840.
REQ-033 reset asserted at cycle 10 of a run -> cv_x=cv_y=0, no done; subsequent REQ-029 stimulus yields REQ-029 results.
REQ-034 x=0, y=0, t_width=t_height=80 -> cv_x=0, cv_y=0, done after 23 cycles.

Source files
------------

// File: rtl/transform_pkg.sv
// Shared types and widths for the coordinate transform.
// Holds the FSM state enum and the datapath width constants.
package transform_pkg;

    localparam int unsigned X_W       = 11;
    localparam int unsigned Y_W       = 10;
    localparam int unsigned PROD_W    = 21;
    localparam int unsigned OUT_W     = 13;
    localparam int unsigned OUT_MAX   = 8191;
    localparam int unsigned DIV_STEPS = PROD_W;
    localparam int unsigned CNT_W     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/transform_div.sv
// Sequential restoring divider: loads on start, then produces one quotient bit
// per cycle for PROD_W cycles; done pulses on the cycle after the last bit.
module transform_div
    import transform_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PROD_W-1:0] dividend,
    input  logic [X_W-1:0]    divisor,
    output logic [PROD_W-1:0] quotient,
    output logic              done
);

    logic [X_W-1:0]  rem;
    logic [X_W-1:0]  dvs;
    logic [CNT_W-1:0] cnt;
    logic [X_W:0]    rem_sh;
    logic            fits;

    // Trial subtraction of the next shifted-in dividend bit.
    always_comb begin
        rem_sh = {rem, quotient[PROD_W-1]};
        fits   = (rem_sh >= {1'b0, dvs});
    end

    // The quotient register doubles as the dividend shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            quotient <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quotient <= dividend;
                rem      <= '0;
                dvs      <= divisor;
                cnt      <= CNT_W'(DIV_STEPS);
            end else if (cnt != '0) begin
                quotient <= {quotient[PROD_W-2:0], fits};
                rem      <= fits ? X_W'(rem_sh - {1'b0, dvs}) : rem_sh[X_W-1:0];
                cnt      <= cnt - CNT_W'(1);
                done     <= (cnt == CNT_W'(1));
            end
        end
    end

endmodule

// File: rtl/transform.sv
// Scales a source coordinate into a target rectangle: cv = src*SCALE / target.
// Optional TRANSFORM_SAT_EN saturates oversized quotients instead of wrapping.
module transform
    import transform_pkg::*;
#(
    parameter int unsigned SCALE_W = 640,
    parameter int unsigned SCALE_H = 480
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [X_W-1:0]    t_width,
    input  logic [Y_W-1:0]    t_height,
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    output logic [OUT_W-1:0]  cv_x,
    output logic [OUT_W-1:0]  cv_y,
    output logic              done,
    output logic              busy
);

    state_t            state;
    logic [X_W-1:0]    lx;
    logic [Y_W-1:0]    ly;
    logic [X_W-1:0]    lw;
    logic [Y_W-1:0]    lh;

    logic              div_start_c;
    logic [PROD_W-1:0] prod_x_c;
    logic [PROD_W-1:0] prod_y_c;
    logic [PROD_W-1:0] q_x;
    logic [PROD_W-1:0] q_y;
    logic              div_done_x;
    logic              div_done_y;

    // Products are formed from the latched operands and captured by the dividers.
    always_comb begin
        div_start_c = (state == MULT);
        prod_x_c    = PROD_W'(32'(lx) * SCALE_W);
        prod_y_c    = PROD_W'(32'(ly) * SCALE_H);
    end

    transform_div u_div_x (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start_c),
        .dividend (prod_x_c),
        .divisor  (lw),
        .quotient (q_x),
        .done     (div_done_x)
    );

    transform_div u_div_y (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start_c),
        .dividend (prod_y_c),
        .divisor  ({1'b0, lh}),
        .quotient (q_y),
        .done     (div_done_y)
    );

    // Reduce a 21-bit quotient to the output width; zero divisor forces full scale.
    function automatic logic [OUT_W-1:0] reduce(input logic [PROD_W-1:0] q, input logic zero);
        if (zero) return OUT_W'(OUT_MAX);
`ifdef TRANSFORM_SAT_EN
        if (q > PROD_W'(OUT_MAX)) return OUT_W'(OUT_MAX);
`endif
        return q[OUT_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cv_x  <= '0;
            cv_y  <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
            lx    <= '0;
            ly    <= '0;
            lw    <= '0;
            lh    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lx    <= x;
                        ly    <= y;
                        lw    <= t_width;
                        lh    <= t_height;
                        busy  <= 1'b1;
                        state <= MULT;
                    end
                end
                MULT: state <= DIV;
                DIV: begin
                    if (div_done_x && div_done_y) begin
                        cv_x  <= reduce(q_x, (lw == '0));
                        cv_y  <= reduce(q_y, (lh == '0));
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_transform.sv
// Self-checking bench for transform against an arithmetic reference model.
`timescale 1ns/1ps
module tb_transform;

    localparam int unsigned SW  = 640;
    localparam int unsigned SH  = 480;
    localparam int          LAT = 23;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] t_width;
    logic [9:0]  t_height;
    logic [10:0] x;
    logic [9:0]  y;
    logic [12:0] cv_x;
    logic [12:0] cv_y;
    logic        done;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    int obs_x;
    int obs_y;

    transform #(.SCALE_W(SW), .SCALE_H(SH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .t_width  (t_width),
        .t_height (t_height),
        .x        (x),
        .y        (y),
        .cv_x     (cv_x),
        .cv_y     (cv_y),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic int model(input int unsigned src, input int unsigned scale, input int unsigned dv);
        longint unsigned q;
        if (dv == 0) return 8191;
        q = longint'(src);
        q = (q * scale) / dv;
`ifdef TRANSFORM_SAT_EN
        return (q > 8191) ? 8191 : int'(q);
`else
        return int'(q % 8192);
`endif
    endfunction

    // Caller is at a negedge; start is sampled on the following posedge.
    task automatic launch(input int w, input int h, input int xi, input int yi);
        t_width  = 11'(w);
        t_height = 10'(h);
        x        = 11'(xi);
        y        = 10'(yi);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs one computation; returns latency, busy/hold violations and done level one cycle later.
    task automatic run(input int w, input int h, input int xi, input int yi,
                       input int inj, input int inj_x,
                       output int lat, output int berr, output int herr, output int extra);
        logic [12:0] hx;
        logic [12:0] hy;
        hx = cv_x;
        hy = cv_y;
        launch(w, h, xi, yi);
        lat  = 0;
        berr = 0;
        herr = 0;
        while (done !== 1'b1 && lat < LAT + 15) begin
            if (busy !== 1'b1) berr++;
            if (cv_x !== hx || cv_y !== hy) herr++;
            if (lat == inj) begin
                x     = 11'(inj_x);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (busy !== 1'b0) berr++;
        obs_x = int'(cv_x);
        obs_y = int'(cv_y);
        @(negedge clk);
        extra = (done === 1'b1) ? 1 : 0;
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        t_width = '0; t_height = '0; x = '0; y = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (cv_x !== 13'd0) begin n_fail++; $display("FAIL reset_cv_x: got %0d expected 0", cv_x); end
        n_checks++; if (cv_y !== 13'd0) begin n_fail++; $display("FAIL reset_cv_y: got %0d expected 0", cv_y); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        int lat, berr, herr, extra;
        run(80, 80, 230, 340, -1, 0, lat, berr, herr, extra);
        n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT); end
        n_checks++; if (obs_x != 1840) begin n_fail++; $display("FAIL basic_cv_x: got %0d expected 1840", obs_x); end
        n_checks++; if (obs_y != 2040) begin n_fail++; $display("FAIL basic_cv_y: got %0d expected 2040", obs_y); end
        n_checks++; if (berr != 0) begin n_fail++; $display("FAIL basic_busy: got %0d violations expected 0", berr); end
        n_checks++; if (herr != 0) begin n_fail++; $display("FAIL basic_hold: got %0d violations expected 0", herr); end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL basic_done_width: got done=%0d next cycle expected 0", extra); end
    endtask

    task automatic test_zero_div();
        int lat, berr, herr, extra;
        run(0, 480, 100, 479, -1, 0, lat, berr, herr, extra);
        n_checks++; if (obs_x != 8191) begin n_fail++; $display("FAIL zdiv_cv_x: got %0d expected 8191", obs_x); end
        n_checks++; if (obs_y != 479) begin n_fail++; $display("FAIL zdiv_cv_y: got %0d expected 479", obs_y); end
        n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL zdiv_latency: got %0d expected %0d", lat, LAT); end
    endtask

    task automatic test_overflow();
        int lat, berr, herr, extra;
        int exp_x;
`ifdef TRANSFORM_SAT_EN
        exp_x = 8191;
`else
        exp_x = 7552;
`endif
        run(1, 1, 2047, 0, -1, 0, lat, berr, herr, extra);
        n_checks++; if (obs_x != exp_x) begin n_fail++; $display("FAIL ovf_cv_x: got %0d expected %0d", obs_x, exp_x); end
        n_checks++; if (obs_y != 0) begin n_fail++; $display("FAIL ovf_cv_y: got %0d expected 0", obs_y); end
    endtask

    task automatic test_ignore_start();
        int lat, berr, herr, extra, n;
        run(80, 80, 230, 340, 5, 10, lat, berr, herr, extra);
        n_checks++; if (obs_x != 1840) begin n_fail++; $display("FAIL ign_cv_x: got %0d expected 1840", obs_x); end
        n_checks++; if (obs_y != 2040) begin n_fail++; $display("FAIL ign_cv_y: got %0d expected 2040", obs_y); end
        n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL ign_latency: got %0d expected %0d", lat, LAT); end
        count_dones(30, n);
        n_checks++; if (n != 0) begin n_fail++; $display("FAIL ign_extra_done: got %0d pulses expected 0", n); end
    endtask

    task automatic test_reset_mid();
        int n;
        launch(80, 80, 230, 340);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if (cv_x !== 13'd0 || cv_y !== 13'd0) begin n_fail++; $display("FAIL rmid_cv: got %0d/%0d expected 0/0", cv_x, cv_y); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        count_dones(30, n);
        n_checks++; if (n != 0) begin n_fail++; $display("FAIL rmid_done: got %0d pulses expected 0", n); end
        test_basic();
    endtask

    task automatic test_zero_inputs();
        int lat, berr, herr, extra;
        run(80, 80, 0, 0, -1, 0, lat, berr, herr, extra);
        n_checks++; if (obs_x != 0 || obs_y != 0) begin n_fail++; $display("FAIL zin_cv: got %0d/%0d expected 0/0", obs_x, obs_y); end
        n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL zin_latency: got %0d expected %0d", lat, LAT); end
    endtask

    task automatic test_random();
        int lat, berr, herr, extra;
        int w, h, xi, yi, ex, ey;
        for (int i = 0; i < 25; i++) begin
            w  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 2047));
            h  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 1023));
            xi = int'($urandom_range(0, 2047));
            yi = int'($urandom_range(0, 1023));
            ex = model(xi, SW, w);
            ey = model(yi, SH, h);
            run(w, h, xi, yi, -1, 0, lat, berr, herr, extra);
            n_checks++; if (obs_x != ex || obs_y != ey) begin
                n_fail++;
                $display("FAIL rand_cv: w=%0d h=%0d x=%0d y=%0d got %0d/%0d expected %0d/%0d", w, h, xi, yi, obs_x, obs_y, ex, ey);
            end
            n_checks++; if (lat != LAT || berr != 0 || herr != 0 || extra != 0) begin
                n_fail++;
                $display("FAIL rand_protocol: got lat=%0d busy_err=%0d hold_err=%0d extra=%0d expected %0d/0/0/0", lat, berr, herr, extra, LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, berr, herr, extra;
        run(80, 80, 230, 340, -1, 0, lat, berr, herr, extra);
        n_checks++; if (obs_x != 1840 || obs_y != 2040) begin n_fail++; $display("FAIL b2b_first: got %0d/%0d expected 1840/2040", obs_x, obs_y); end
        run(3, 7, 1000, 900, -1, 0, lat, berr, herr, extra);
        n_checks++; if (obs_x != model(1000, SW, 3) || obs_y != model(900, SH, 7)) begin
            n_fail++;
            $display("FAIL b2b_second: got %0d/%0d expected %0d/%0d", obs_x, obs_y, model(1000, SW, 3), model(900, SH, 7));
        end
        n_checks++; if (lat != LAT || herr != 0) begin n_fail++; $display("FAIL b2b_protocol: got lat=%0d hold_err=%0d expected %0d/0", lat, herr, LAT); end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_basic();
        test_zero_div();
        test_overflow();
        test_ignore_start();
        test_reset_mid();
        test_zero_inputs();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
